vga_scanout: RTL and testbench

//  Multi-mode VGA scan-out engine; successor to the fixed 640x480 output stage.

---
 rtl/vga_pkg.sv | 47 ++++
 rtl/vga_timing_gen.sv | 75 +++++++
 rtl/vga_scanout.sv | 183 ++++++++++++++++++
 tb/tb_vga_scanout.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - Shared types, default palette and raster timing helpers for the VGA scan-out
package vga_pkg;

    typedef enum logic [1:0] {
        MODE_DIRECT8 = 2'd0,
        MODE_PAL4    = 2'd1,
        MODE_PAL2    = 2'd2,
        MODE_BLANK   = 2'd3
    } mode_t;

    // Side information for one pixel that travels alongside the video RAM read
    typedef struct packed {
        logic       visible;
        logic       hSyncOn;
        logic       vSyncOn;
        logic [1:0] pixelSel;
        mode_t      pixelMode;
    } pixel_tag_t;

    localparam pixel_tag_t TAG_IDLE = '{
        visible:   1'b0,
        hSyncOn:   1'b0,
        vSyncOn:   1'b0,
        pixelSel:  2'b00,
        pixelMode: MODE_BLANK
    };

    // CGA colours packed as {B[1:0], G[2:0], R[2:0]}; leftmost element is entry 15
    localparam logic [15:0][7:0] DEFAULT_PALETTE = {
        8'hFF, 8'h7F, 8'hD7, 8'h57, 8'hFA, 8'h7A, 8'hD2, 8'h52,
        8'hAD, 8'h15, 8'h85, 8'h05, 8'hA8, 8'h28, 8'h80, 8'h00
    };

    function automatic int timingTotal(input int visible, input int front,
                                       input int syncWidth, input int back);
        return visible + front + syncWidth + back;
    endfunction

    function automatic int syncStart(input int visible, input int front);
        return visible + front;
    endfunction

    function automatic int syncEnd(input int visible, input int front, input int syncWidth);
        return visible + front + syncWidth;
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - Pixel tick divider, raster counters and sync/visible/vblank decode
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int CLK_DIV   = 2
) (
    input  logic       clock,
    input  logic       reset,
    output logic       tick,
    output logic [9:0] xPos,
    output logic [9:0] yPos,
    output logic       visible,
    output logic       hSyncOn,
    output logic       vSyncOn,
    output logic       frameStart,
    output logic       vblankStart
);

    localparam int H_TOTAL = timingTotal(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
    localparam int V_TOTAL = timingTotal(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [9:0]       H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0]       H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0]       V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0]       HS_START = 10'(syncStart(H_VISIBLE, H_FRONT));
    localparam logic [9:0]       HS_END   = 10'(syncEnd(H_VISIBLE, H_FRONT, H_SYNC));
    localparam logic [9:0]       VS_START = 10'(syncStart(V_VISIBLE, V_FRONT));
    localparam logic [9:0]       VS_END   = 10'(syncEnd(V_VISIBLE, V_FRONT, V_SYNC));
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] divCount;

    // Each counter position lasts CLK_DIV clocks, the tick falls on its last clock
    always_ff @(posedge clock) begin
        if (reset || tick) begin
            divCount <= '0;
        end else begin
            divCount <= divCount + 1'b1;
        end
    end

    assign tick = (divCount == DIV_LAST);

    // Raster position: x wraps into the next line, y wraps at end of frame
    always_ff @(posedge clock) begin
        if (reset) begin
            xPos <= '0;
            yPos <= '0;
        end else if (tick) begin
            if (xPos == H_LAST) begin
                xPos <= '0;
                yPos <= (yPos == V_LAST) ? 10'd0 : yPos + 10'd1;
            end else begin
                xPos <= xPos + 10'd1;
            end
        end
    end

    assign visible     = (xPos < H_VIS) && (yPos < V_VIS);
    assign hSyncOn     = (xPos >= HS_START) && (xPos < HS_END);
    assign vSyncOn     = (yPos >= VS_START) && (yPos < VS_END);
    assign frameStart  = (xPos == 10'd0) && (yPos == 10'd0);
    assign vblankStart = tick && (xPos == 10'd0) && (yPos == V_VIS);

endmodule

// File: rtl/vga_scanout.sv
// rtl/vga_scanout.sv - Multi-mode VGA scan-out: address generation, fetch delay line, palette, colour mux
module vga_scanout
    import vga_pkg::*;
#(
    parameter int H_VISIBLE    = 640,
    parameter int H_FRONT      = 16,
    parameter int H_SYNC       = 96,
    parameter int H_BACK       = 48,
    parameter int V_VISIBLE    = 480,
    parameter int V_FRONT      = 10,
    parameter int V_SYNC       = 2,
    parameter int V_BACK       = 33,
    parameter int CLK_DIV      = 2,
    parameter int READ_LATENCY = 1,
    parameter bit SYNC_ACTIVE  = 1'b0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  mode,
    output logic [16:0] videoAddress,
    input  logic [7:0]  videoData,
    input  logic        paletteWrite,
    input  logic [3:0]  paletteIndex,
    input  logic [7:0]  paletteData,
    output logic [7:0]  videoOutput,
    output logic        hSync,
    output logic        vSync,
    output logic        videoActive,
    output logic        vblankPulse
);

    localparam int   PIPE_DEPTH = (READ_LATENCY > 0) ? READ_LATENCY : 1;
    localparam int   TAP        = (READ_LATENCY > 0) ? READ_LATENCY - 1 : 0;
    localparam logic SYNC_ON    = SYNC_ACTIVE;

    logic        tick;
    logic [9:0]  xPos;
    logic [9:0]  yPos;
    logic        visible;
    logic        hSyncOn;
    logic        vSyncOn;
    logic        frameStart;
    logic        vblankStart;

    mode_t       activeMode;
    mode_t       curMode;
    pixel_tag_t  curTag;
    pixel_tag_t  outTag;
    pixel_tag_t  tagPipe [0:PIPE_DEPTH-1];
    logic [7:0]  palette [0:15];
    logic [16:0] pal2Address;
    logic [3:0]  nibble;
    logic [1:0]  crumb;
    logic [7:0]  pixelColour;

    vga_timing_gen #(
        .H_VISIBLE (H_VISIBLE),
        .H_FRONT   (H_FRONT),
        .H_SYNC    (H_SYNC),
        .H_BACK    (H_BACK),
        .V_VISIBLE (V_VISIBLE),
        .V_FRONT   (V_FRONT),
        .V_SYNC    (V_SYNC),
        .V_BACK    (V_BACK),
        .CLK_DIV   (CLK_DIV)
    ) timing (
        .clock       (clock),
        .reset       (reset),
        .tick        (tick),
        .xPos        (xPos),
        .yPos        (yPos),
        .visible     (visible),
        .hSyncOn     (hSyncOn),
        .vSyncOn     (vSyncOn),
        .frameStart  (frameStart),
        .vblankStart (vblankStart)
    );

    // Mode is only taken at the frame-start position so a frame never mixes modes
    always_ff @(posedge clock) begin
        if (reset) begin
            activeMode <= MODE_BLANK;
        end else if (tick && frameStart) begin
            activeMode <= mode_t'(mode);
        end
    end

    // The frame-start pixel itself already uses the newly sampled mode
    assign curMode     = frameStart ? mode_t'(mode) : activeMode;
    assign pal2Address = 17'(yPos) * 17'd160 + 17'(xPos[9:2]);

    // Byte address for the pixel at the current counter position
    always_comb begin
        videoAddress = 17'd0;
        case (curMode)
            MODE_DIRECT8, MODE_PAL4: videoAddress = {yPos[8:1], xPos[9:1]};
            MODE_PAL2:               videoAddress = pal2Address;
            default:                 videoAddress = 17'd0;
        endcase
    end

    // Collect everything the colour stage needs about the current pixel
    always_comb begin
        curTag           = TAG_IDLE;
        curTag.visible   = visible;
        curTag.hSyncOn   = hSyncOn;
        curTag.vSyncOn   = vSyncOn;
        curTag.pixelSel  = xPos[1:0];
        curTag.pixelMode = curMode;
    end

    // Hold the pixel tag back until its byte returns from video RAM
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < PIPE_DEPTH; i++) begin
                tagPipe[i] <= TAG_IDLE;
            end
        end else if (tick) begin
            tagPipe[0] <= curTag;
            for (int i = 1; i < PIPE_DEPTH; i++) begin
                tagPipe[i] <= tagPipe[i-1];
            end
        end
    end

    assign outTag = (READ_LATENCY == 0) ? curTag : tagPipe[TAP];

    // CPU palette; a lookup on the write clock still sees the old entry
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                palette[i] <= DEFAULT_PALETTE[i];
            end
        end else if (paletteWrite) begin
            palette[paletteIndex] <= paletteData;
        end
    end

    // Pick the pixel's bits out of the returned byte and resolve the colour
    always_comb begin
        nibble = outTag.pixelSel[0] ? videoData[3:0] : videoData[7:4];
        case (outTag.pixelSel)
            2'd0:    crumb = videoData[7:6];
            2'd1:    crumb = videoData[5:4];
            2'd2:    crumb = videoData[3:2];
            default: crumb = videoData[1:0];
        endcase
        pixelColour = 8'h00;
        if (outTag.visible) begin
            case (outTag.pixelMode)
                MODE_DIRECT8: pixelColour = videoData;
                MODE_PAL4:    pixelColour = palette[nibble];
                MODE_PAL2:    pixelColour = palette[{2'b00, crumb}];
                default:      pixelColour = 8'h00;
            endcase
        end
    end

    // Registered outputs keep colour and syncs of one pixel aligned
    always_ff @(posedge clock) begin
        if (reset) begin
            videoOutput <= 8'h00;
            hSync       <= ~SYNC_ON;
            vSync       <= ~SYNC_ON;
            videoActive <= 1'b0;
        end else if (tick) begin
            videoOutput <= pixelColour;
            hSync       <= outTag.hSyncOn ? SYNC_ON : ~SYNC_ON;
            vSync       <= outTag.vSyncOn ? SYNC_ON : ~SYNC_ON;
            videoActive <= outTag.visible;
        end
    end

    // One-clock vertical blanking interrupt, not delayed with the pixels
    always_ff @(posedge clock) begin
        if (reset) begin
            vblankPulse <= 1'b0;
        end else begin
            vblankPulse <= vblankStart;
        end
    end

endmodule

// File: tb/tb_vga_scanout.sv
// tb/tb_vga_scanout.sv - Directed self-checking bench for vga_scanout on a reduced raster
module tb_vga_scanout;

    // Reduced raster: H_TOTAL=24, V_TOTAL=12, two clocks per pixel, one tick read latency
    localparam int H_VISIBLE = 16;
    localparam int H_FRONT   = 2;
    localparam int H_SYNC    = 4;
    localparam int H_BACK    = 2;
    localparam int V_VISIBLE = 8;
    localparam int V_FRONT   = 1;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 1;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  mode;
    logic [16:0] videoAddress;
    logic [7:0]  videoData;
    logic        paletteWrite;
    logic [3:0]  paletteIndex;
    logic [7:0]  paletteData;
    logic [7:0]  videoOutput;
    logic        hSync;
    logic        vSync;
    logic        videoActive;
    logic        vblankPulse;

    int errors = 0;
    int checks = 0;
    int n      = 0;
    int vLow   = 0;
    int hLow;
    int fallAt;
    logic prevHs;

    vga_scanout #(
        .H_VISIBLE    (H_VISIBLE),
        .H_FRONT      (H_FRONT),
        .H_SYNC       (H_SYNC),
        .H_BACK       (H_BACK),
        .V_VISIBLE    (V_VISIBLE),
        .V_FRONT      (V_FRONT),
        .V_SYNC       (V_SYNC),
        .V_BACK       (V_BACK),
        .CLK_DIV      (2),
        .READ_LATENCY (1),
        .SYNC_ACTIVE  (1'b0)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .mode         (mode),
        .videoAddress (videoAddress),
        .videoData    (videoData),
        .paletteWrite (paletteWrite),
        .paletteIndex (paletteIndex),
        .paletteData  (paletteData),
        .videoOutput  (videoOutput),
        .hSync        (hSync),
        .vSync        (vSync),
        .videoActive  (videoActive),
        .vblankPulse  (vblankPulse)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One clock; n counts posedges since reset release, sampling 1 time unit after the edge
    task automatic clk1();
        @(posedge clock);
        #1;
        n++;
        if (vSync === 1'b0) vLow++;
    endtask

    task automatic goTo(input int target);
        while (n < target) clk1();
    endtask

    initial begin
        reset = 1'b1; mode = 2'd0; videoData = 8'hFF;
        paletteWrite = 1'b0; paletteIndex = 4'd0; paletteData = 8'h00;
        repeat (3) @(posedge clock);
        #1;
        check("rst_video",  videoOutput,  8'h00);
        check("rst_hsync",  hSync,        1'b1);
        check("rst_vsync",  vSync,        1'b1);
        check("rst_active", videoActive,  1'b0);
        check("rst_vblank", vblankPulse,  1'b0);
        check("rst_addr",   videoAddress, 17'd0);
        reset = 1'b0;
        n = 0; vLow = 0;

        // Frame 0, direct8. Pixel p shows on the outputs from clock 2p+4.
        goTo(34); check("d8_x15_colour", videoOutput, 8'hFF); check("d8_x15_active", videoActive, 1'b1);
        goTo(36); check("d8_x16_blank", videoOutput, 8'h00);  check("d8_x16_active", videoActive, 1'b0);
        goTo(38); check("hs_x17", hSync, 1'b1);
        goTo(40); check("hs_x18", hSync, 1'b0);
        goTo(46); check("hs_x21", hSync, 1'b0);
        goTo(48); check("hs_x22", hSync, 1'b1);

        hLow = 0; fallAt = -1; prevHs = hSync;
        while (n < 96) begin
            clk1();
            if (hSync === 1'b0) hLow++;
            if (prevHs === 1'b1 && hSync === 1'b0 && fallAt < 0) fallAt = n;
            prevHs = hSync;
        end
        check("hs_low_clocks", hLow, 8);
        check("hs_period", fallAt - 40, 48);

        goTo(100); videoData = 8'h00;
        goTo(154); check("d8_addr_5_3", videoAddress, 17'd514);
        goTo(156); videoData = 8'hA5;
        goTo(157); check("d8_not_early", videoOutput, 8'h00);
        goTo(158); check("d8_a5_colour", videoOutput, 8'hA5); check("d8_a5_active", videoActive, 1'b1);

        // Mode request mid-frame must wait for the next frame start
        goTo(240); mode = 2'd2;
        goTo(294); videoData = 8'h42;
        goTo(296); check("deferred_mode", videoOutput, 8'h42);

        goTo(385); check("vbl_before", vblankPulse, 1'b0);
        goTo(386); check("vbl_pulse",  vblankPulse, 1'b1);
        goTo(387); check("vbl_after",  vblankPulse, 1'b0);
        goTo(434); check("vs_y8",  vSync, 1'b1);
        goTo(436); check("vs_y9",  vSync, 1'b0);
        goTo(530); check("vs_y10", vSync, 1'b0);
        goTo(532); check("vs_y11", vSync, 1'b1);

        // Frame 1, pal2 on line 2
        goTo(680); videoData = 8'hE4;
        goTo(684); check("p2_x4", videoOutput, 8'hA8);
        goTo(686); check("p2_x5", videoOutput, 8'h28); check("p2_addr_7_2", videoAddress, 17'd321);
        goTo(688); check("p2_x6", videoOutput, 8'h80);
        goTo(690); check("p2_x7", videoOutput, 8'h00);
        goTo(800); mode = 2'd1;
        goTo(962); check("vbl_frame1", vblankPulse, 1'b1); check("vs_low_clocks", vLow, 96);

        // Frame 2, pal4 on line 1
        goTo(1160); paletteWrite = 1'b1; paletteIndex = 4'd9; paletteData = 8'h3C;
        goTo(1161); paletteWrite = 1'b0;
        goTo(1222); videoData = 8'h9F;
        goTo(1224); check("p4_x10", videoOutput, 8'h3C);
        goTo(1225); paletteWrite = 1'b1; paletteIndex = 4'd15; paletteData = 8'h11;
        goTo(1226); check("p4_x11_old", videoOutput, 8'hFF); paletteWrite = 1'b0;
        goTo(1230); check("p4_x13_new", videoOutput, 8'h11);
        goTo(1236); check("p4_x16_blank", videoOutput, 8'h00); check("p4_x16_active", videoActive, 1'b0);

        // Reset in the middle of a line
        goTo(1240); reset = 1'b1;
        clk1();
        check("mid_rst_video",  videoOutput,  8'h00);
        check("mid_rst_hsync",  hSync,        1'b1);
        check("mid_rst_vsync",  vSync,        1'b1);
        check("mid_rst_active", videoActive,  1'b0);
        check("mid_rst_addr",   videoAddress, 17'd0);
        reset = 1'b0;
        n = 0;
        goTo(4);  check("post_rst_pal9", videoOutput, 8'hD2); check("post_rst_active", videoActive, 1'b1);
        goTo(10); check("post_rst_addr", videoAddress, 17'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
